iter_shift_unit: RTL and testbench
==================================

# iter_shift_unit

Multi-cycle parametrised shift unit for the CPU datapath, generalising the fixed immediate-offset left shift into a variable-amount, multi-mode shifter. It executes SLL, SRL, SRA and ROTL on a WIDTH-bit operand, shifting at most STEP bits per clock. A start/busy/done handshake lets the control unit stall while the shift completes. It sits beside the ALU and serves both shift instructions and branch-offset scaling (SLL by 2).

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8.
- STEP, 4: maximum bits shifted per cycle; power of two, 1..WIDTH.
- SHAMT_W, $clog2(WIDTH): shift-amount width (derived; not overridden).

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL.
- data_in  in  WIDTH  operand, captured with start.
- shamt  in  SHAMT_W  shift amount, captured with start.
- busy  out  1  high while an operation is in flight (SHIFT state).
- done  out  1  one-cycle pulse; result is valid that cycle.
- result  out  WIDTH  shifted value; holds until the next accepted start.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1: capture data_in into the working register, shamt into rem and op into op_q.
  - If shamt=0, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each cycle: k = min(STEP, rem). Shift the working register by k per op_q, then rem -= k.
  - If rem-k=0, go to DONE.
  - start is ignored.
- DONE: done=1 for exactly one cycle; result = working register.
  - start=1 in DONE is accepted exactly as in IDLE, since busy=0.
  - Otherwise go to IDLE.
- Mode rules:
  - SLL: zero fill at the LSB.
  - SRL: zero fill at the MSB.
  - SRA: replicate the operand MSB captured at start.
  - ROTL: bits leaving the MSB re-enter at the LSB.
- Width rule: all arithmetic stays modulo WIDTH. Since shamt < WIDTH, rem never underflows. No overflow or flag output.
- op and shamt are latched at start. Input changes during SHIFT have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, rem=0.
- Reset takes priority over everything, including mid-SHIFT and during DONE. The in-flight result is discarded and no done pulse follows.
- Latency: start accepted at edge t → done high in cycle t+1+N, where N = ceil(shamt/STEP).
  - shamt=0 → t+1.
  - WIDTH=32, STEP=4, shamt=31 → t+9.
- busy is high exactly N cycles (the SHIFT cycles). It is low in IDLE and DONE.
- Back-to-back: start held high through DONE gives a throughput of one operation per N+1 cycles with no idle gap.
- result is registered; no combinational path from any input to any output.

## Structure
- Shared definitions file (cpu_defs): op encodings SH_SLL/SH_SRL/SH_SRA/SH_ROTL and state encodings. The ALU decoder uses the same op constants.
- One sub-module, shift_step: purely combinational.
  - Inputs: value, k (0..STEP), op.
  - Output: value shifted by k.
  - Instantiated once; the FSM and registers live in iter_shift_unit.

## Test plan
All scenarios use WIDTH=32, STEP=4.
- SLL, data_in=0x0000_0001, shamt=2 → result=0x0000_0004, done at t+2, busy high 1 cycle.
- SRA, data_in=0x8000_0000, shamt=31 → result=0xFFFF_FFFF at t+9. Same with SRL → 0x0000_0001.
- ROTL, data_in=0x8000_0001, shamt=4 → result=0x0000_0018 at t+2. shamt=0 with any op → result=data_in at t+1, busy never high.
- start pulsed with new data during SHIFT → ignored; result matches the original operand. start held high from DONE → second operation accepted with no idle cycle.
- rst asserted in the 3rd SHIFT cycle of an SRL, shamt=20 → next cycle busy=0, done=0, result=0; no later done pulse.
- Random op/data/shamt sweep (≥10k ops) against a reference model: result and done cycle must match the latency formula.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU datapath definitions: shift-op and shift-FSM state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs;

  // Shift operation encodings. The ALU decoder uses the same constants.
  localparam int SH_OP_W = 2;

  typedef enum logic [SH_OP_W-1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTL = 2'b11
  } sh_op_e;

  // Iterative shifter control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_e;

endpackage : cpu_defs

// File: rtl/shift_step.sv
// One slice of the iterative shifter: shifts a value by k (0..STEP) bits per op.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when the output is used.
module shift_step
  import cpu_defs::*;
#(
  parameter int  WIDTH = 32,
  parameter int  STEP  = 4,
  localparam int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [KW-1:0]    k_i,
  input  sh_op_e           op_i,
  output logic [WIDTH-1:0] value_o
);

  // Apply one bounded shift step. SRA relies on the MSB of the working value,
  // which an arithmetic shift never changes, so it keeps the captured sign.
  always_comb begin
    value_o = value_i;
    case (op_i)
      SH_SLL:  value_o = value_i << k_i;
      SH_SRL:  value_o = value_i >> k_i;
      SH_SRA:  value_o = $signed(value_i) >>> k_i;
      // A shift by WIDTH yields zero, so k=0 degenerates to the identity.
      SH_ROTL: value_o = (value_i << k_i) | (value_i >> (WIDTH - int'(k_i)));
      default: value_o = value_i;
    endcase
  end

endmodule : shift_step

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTL shifter moving at most STEP bits per clock.
// Latency: done pulses ceil(shamt/STEP)+1 cycles after start is accepted.
// Backpressure: start is only taken while busy=0 (IDLE or DONE); ignored in SHIFT.
module iter_shift_unit
  import cpu_defs::*;
#(
  parameter int  WIDTH   = 32,
  parameter int  STEP    = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SH_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int KW = $clog2(STEP + 1);

  sh_state_e          state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  sh_op_e             op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [KW-1:0]      step_k;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   step_val;

  // Bits moved this cycle: the smaller of STEP and what is left to shift.
  always_comb begin
    step_k = KW'(STEP);
    if (int'(rem_q) < STEP) begin
      step_k = KW'(rem_q);
    end
    rem_next = rem_q - SHAMT_W'(step_k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_shift_step (
    .value_i (work_q),
    .k_i     (step_k),
    .op_i    (op_q),
    .value_o (step_val)
  );

  // Next-state logic: accept in IDLE/DONE, iterate in SHIFT, publish on entry to DONE.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d = data_in;
          rem_d  = shamt;
          op_d   = sh_op_e'(op);
          if (shamt == '0) begin
            // Nothing to shift: the operand itself is the result next cycle.
            state_d  = ST_DONE;
            result_d = data_in;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = step_val;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d  = ST_DONE;
          result_d = step_val;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= SH_SLL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule : iter_shift_unit

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit (WIDTH=32, STEP=4).
// Directed cases plus a randomized sweep against a behavioural shift model.
// Checks result value, done cycle, busy cycle count and reset behaviour.
module tb_iter_shift_unit;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [SW-1:0]    shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  iter_shift_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: whole shift in one go, straight from the mode rules.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input int s);
    logic [31:0] r;
    case (o)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = (d >> s) | ((d[31] && s > 0) ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      default: r = (s == 0) ? d : ((d << s) | (d >> (32 - s)));
    endcase
    return r;
  endfunction

  // Issue one operation (caller is #1 past an edge with the DUT in IDLE/DONE),
  // then track done latency, busy cycles and the result. 'chain' leaves the
  // DUT in DONE so the next call starts back-to-back; 'poke' pulses start with
  // junk during the first SHIFT cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input int s, input logic [31:0] exp, input bit chain,
                        input bit poke);
    int cyc;
    int nbusy;
    int n_exp;
    n_exp   = (s + STEP - 1) / STEP;
    op      = o;
    data_in = d;
    shamt   = SW'(s);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    op      = 2'($urandom);
    data_in = $urandom;
    shamt   = SW'($urandom);
    cyc     = 1;
    nbusy   = 0;
    while (!done && cyc <= 20) begin
      if (busy) nbusy++;
      if (poke && cyc == 1) begin
        start   = 1'b1;
        data_in = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ".done_cycle"}, 32'(cyc), 32'(1 + n_exp));
    check({tag, ".busy_cycles"}, 32'(nbusy), 32'(n_exp));
    check({tag, ".result"}, result, exp);
    if (!chain) begin
      @(posedge clk); #1;
      check({tag, ".done_one_cycle"}, {31'b0, done}, 32'd0);
      check({tag, ".idle_busy"}, {31'b0, busy}, 32'd0);
      check({tag, ".result_hold"}, result, exp);
    end
  endtask

  initial begin
    int seen_done;
    logic [1:0]  ro;
    logic [31:0] rd;
    int          rs;

    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    data_in = '0;
    shamt   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.done", {31'b0, done}, 32'd0);
    check("reset.result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations.
    run_op("sll_1_2",    2'b00, 32'h0000_0001, 2,  32'h0000_0004, 1'b0, 1'b0);
    run_op("sra_min_31", 2'b10, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("srl_min_31", 2'b01, 32'h8000_0000, 31, 32'h0000_0001, 1'b0, 1'b0);
    run_op("rotl_4",     2'b11, 32'h8000_0001, 4,  32'h0000_0018, 1'b0, 1'b0);
    run_op("zero_sll",   2'b00, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 1'b0, 1'b0);
    run_op("zero_srl",   2'b01, 32'h1234_5678, 0,  32'h1234_5678, 1'b0, 1'b0);
    run_op("zero_sra",   2'b10, 32'h8765_4321, 0,  32'h8765_4321, 1'b0, 1'b0);
    run_op("zero_rotl",  2'b11, 32'hA5A5_0F0F, 0,  32'hA5A5_0F0F, 1'b0, 1'b0);
    run_op("poke_sll",   2'b00, 32'h0000_00FF, 12, 32'h000F_F000, 1'b0, 1'b1);
    run_op("b2b_a",      2'b10, 32'hF000_0000, 8,  32'hFFF0_0000, 1'b1, 1'b0);
    run_op("b2b_b",      2'b11, 32'h1234_5678, 16, 32'h5678_1234, 1'b1, 1'b0);
    run_op("b2b_c",      2'b01, 32'hFFFF_FFFF, 0,  32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset during the third SHIFT cycle of an SRL by 20.
    op      = 2'b01;
    data_in = 32'hFFFF_0000;
    shamt   = SW'(20);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid.busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid.busy", {31'b0, busy}, 32'd0);
    check("rst_mid.done", {31'b0, done}, 32'd0);
    check("rst_mid.result", result, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("rst_mid.no_late_done", 32'(seen_done), 32'd0);

    // Randomized sweep; occasionally chained back-to-back or poked mid-shift.
    for (int i = 0; i < 10000; i++) begin
      ro = 2'($urandom);
      rd = $urandom;
      rs = int'($urandom_range(0, 31));
      run_op("rand", ro, rd, rs, ref_shift(ro, rd, rs),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0));
    end
    // Return to IDLE after any chained tail.
    @(posedge clk); #1;
    check("final.busy", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_iter_shift_unit
